// File: rtl/demux_1_8_reg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1_8_reg
//  Purpose  : Registered 1-to-LANES demultiplexer with valid/ready handshake.
//             One WIDTH-bit beat plus a lane select is accepted per cycle and
//             delivered, strictly in order, to exactly one consumer lane. A
//             2-entry head/skid buffer keeps in_ready a pure register output,
//             so per-lane backpressure never reaches the producer
//             combinationally.
//  Revision : 1.0  initial release
// ============================================================================
module demux_1_8_reg #(
    parameter int WIDTH = 64,   // payload width in bits
    parameter int LANES = 8     // number of output lanes, 2..8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_sel,
    input  logic [WIDTH-1:0]  in_data,
    output logic [LANES-1:0]  out_valid,
    input  logic [LANES-1:0]  out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              sel_err
);

    // The select field is fixed at 3 bits regardless of LANES.
    localparam int SEL_W = 3;

    // Buffer occupancy: EMPTY = nothing held, ONE = head only,
    // TWO = head plus skid (producer stalled).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Head entry drives the outputs; skid entry catches the beat that
    // arrives while the head is stalled.
    logic [SEL_W-1:0]   r_hsel;
    logic [WIDTH-1:0]   r_hdata;
    logic [SEL_W-1:0]   r_ssel;
    logic [WIDTH-1:0]   r_sdata;

    logic               r_in_ready;
    logic               r_sel_err;

    logic               w_in_fire;
    logic               w_sel_legal;
    logic               w_accept;
    logic               w_illegal;
    logic               w_out_fire;
    logic               w_head_valid;
    logic [LANES-1:0]   w_lane_hit;

    logic               w_load_head_in;
    logic               w_load_head_skid;
    logic               w_load_skid;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign w_in_fire    = in_valid & r_in_ready;
    assign w_head_valid = (r_state != ST_EMPTY);

    // With eight lanes every 3-bit select addresses a real lane, so the
    // range check collapses to a constant.
    generate
        if (LANES >= 8) begin : g_sel_all_legal
            assign w_sel_legal = 1'b1;
        end else begin : g_sel_range
            assign w_sel_legal = (in_sel < SEL_W'(LANES));
        end
    endgenerate

    // An illegal beat is still consumed (the producer sees it accepted)
    // but it never enters the buffer.
    assign w_accept  = w_in_fire &  w_sel_legal;
    assign w_illegal = w_in_fire & ~w_sel_legal;

    // One-hot lane decode of the head select.
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign w_lane_hit[k] = (r_hsel == SEL_W'(k));
        end
    endgenerate

    assign out_valid  = w_head_valid ? w_lane_hit : '0;
    assign out_data   = r_hdata;
    // Only the addressed lane's ready matters; others are masked by the
    // one-hot out_valid.
    assign w_out_fire = |(out_valid & out_ready);

    assign in_ready   = r_in_ready;
    assign sel_err    = r_sel_err;

    // ------------------------------------------------------------------
    // Next-state and buffer-load decisions
    // ------------------------------------------------------------------
    // Occupancy transitions; load strobes default to idle.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = ST_ONE;
                    w_load_head_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_out_fire) begin
                    // Head drains and refills on the same edge.
                    w_state_nxt    = ST_ONE;
                    w_load_head_in = 1'b1;
                end else if (w_accept) begin
                    // Head stalled: park the new beat in the skid entry.
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the drain side can move.
                if (w_out_fire) begin
                    w_state_nxt      = ST_ONE;
                    w_load_head_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // State register; in_ready is derived from the next state so that it
    // is a flop output and never a function of out_ready in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end

    // Head entry: loads from the input or promotes the skid entry; held
    // otherwise so sel/data stay stable while the addressed lane stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsel  <= '0;
            r_hdata <= '0;
        end else if (w_load_head_in) begin
            r_hsel  <= in_sel;
            r_hdata <= in_data;
        end else if (w_load_head_skid) begin
            r_hsel  <= r_ssel;
            r_hdata <= r_sdata;
        end
    end

    // Skid entry: captures the beat accepted while the head is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ssel  <= '0;
            r_sdata <= '0;
        end else if (w_load_skid) begin
            r_ssel  <= in_sel;
            r_sdata <= in_data;
        end
    end

    // Sticky illegal-select flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else if (w_illegal) begin
            r_sel_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_1_8_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1_8_reg
//  Purpose  : Scoreboard bench for demux_1_8_reg. Two instances are driven:
//             LANES=8 (dut 0) and LANES=6 (dut 1, exercises illegal selects).
//             The reference model is an in-order queue of accepted beats
//             holding at most two entries.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_1_8_reg;

    typedef struct packed {
        logic [2:0]  sel;
        logic [63:0] data;
    } beat_t;

    logic              clk;
    logic              reset;
    logic [1:0]        iv;
    logic [1:0][2:0]   isel;
    logic [1:0][63:0]  idata;
    logic [1:0][7:0]   ordy;

    logic              ir8, ir6, se8, se6;
    logic [7:0]        ov8;
    logic [5:0]        ov6;
    logic [63:0]       od8, od6;

    int                checks = 0;
    int                errors = 0;

    beat_t             q0[$];
    beat_t             q1[$];
    logic              err_m  [2];
    logic [63:0]       last_m [2];

    demux_1_8_reg #(.WIDTH(64), .LANES(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iv[0]),
        .in_ready  (ir8),
        .in_sel    (isel[0]),
        .in_data   (idata[0]),
        .out_valid (ov8),
        .out_ready (ordy[0]),
        .out_data  (od8),
        .sel_err   (se8)
    );

    demux_1_8_reg #(.WIDTH(64), .LANES(6)) dut6 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iv[1]),
        .in_ready  (ir6),
        .in_sel    (isel[1]),
        .in_data   (idata[1]),
        .out_valid (ov6),
        .out_ready (ordy[1][5:0]),
        .out_data  (od6),
        .sel_err   (se6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model queue helpers ----------------
    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic qpush(input int d, input beat_t b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic qclear(input int d);
        if (d == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic check(input string name, input int d,
                         input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, got, exp, $time);
        end
    endtask

    // One model step per negative edge: compare outputs, then apply the
    // transfers that the coming rising edge will perform.
    task automatic sb_step(input int d, input logic [7:0] ov, input logic [63:0] od,
                           input logic irdy, input logic serr);
        int          lanes;
        beat_t       f;
        beat_t       nb;
        logic [7:0]  rdy;
        logic        exp_ready;
        logic        fire_out;
        lanes = (d == 0) ? 8 : 6;
        if (reset) begin
            qclear(d);
            err_m[d]  = 1'b0;
            last_m[d] = '0;
            check("reset_out_valid", d, {56'd0, ov}, 64'd0);
            check("reset_out_data",  d, od, 64'd0);
            check("reset_in_ready",  d, {63'd0, irdy}, 64'd1);
            check("reset_sel_err",   d, {63'd0, serr}, 64'd0);
        end else begin
            exp_ready = (qsize(d) < 2);
            if (qsize(d) > 0) begin
                f = qfront(d);
                check("out_valid", d, {56'd0, ov}, 64'd1 << f.sel);
                check("out_data",  d, od, f.data);
            end else begin
                check("out_valid_idle", d, {56'd0, ov}, 64'd0);
                check("out_data_held",  d, od, last_m[d]);
            end
            check("in_ready", d, {63'd0, irdy}, {63'd0, exp_ready});
            check("sel_err",  d, {63'd0, serr}, {63'd0, err_m[d]});

            rdy      = ordy[d];
            fire_out = (qsize(d) > 0) && rdy[f.sel];
            if (fire_out) begin
                last_m[d] = f.data;
                qpop(d);
            end
            if (iv[d] && exp_ready) begin
                nb.sel  = isel[d];
                nb.data = idata[d];
                if (int'(nb.sel) < lanes) qpush(d, nb);
                else                      err_m[d] = 1'b1;
            end
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        sb_step(0, ov8, od8, ir8, se8);
        sb_step(1, {2'b00, ov6}, od6, ir6, se6);
    end

    // ---------------- driver ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input logic [2:0] s, input logic [63:0] v);
        logic acc;
        iv[d]    = 1'b1;
        isel[d]  = s;
        idata[d] = v;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = (d == 0) ? ir8 : ir6;
            @(posedge clk);
            #1;
            if (acc) begin
                iv[d] = 1'b0;
                return;
            end
        end
        $display("FAIL send_timeout dut%0d: in_ready never rose within 50 cycles", d);
        $fatal(1);
    endtask

    initial begin
        reset = 1'b1;
        iv    = '0;
        isel  = '0;
        idata = '0;
        ordy  = {8'hFF, 8'hFF};
        idle(3);
        reset = 1'b0;
        idle(1);

        // single beat to lane 5
        send(0, 3'd5, 64'hDEAD_BEEF_0000_0005);
        idle(3);

        // back-to-back stream
        for (int i = 0; i < 16; i++) send(0, 3'(i % 8), 64'(i));
        idle(3);

        // backpressure: lane 2 stalled, lane 6 ready but behind it
        ordy[0] = 8'b0100_0000;
        send(0, 3'd2, 64'hAAAA_0000_0000_0002);
        send(0, 3'd6, 64'hBBBB_0000_0000_0006);
        idle(4);
        ordy[0] = 8'hFF;
        idle(3);

        // illegal select on the 6-lane instance, then a legal beat
        send(1, 3'd7, 64'h7777_7777_7777_7777);
        idle(2);
        send(1, 3'd0, 64'h0000_0000_1234_5678);
        idle(3);

        // simultaneous accept and deliver
        send(0, 3'd1, 64'h1111);
        send(0, 3'd3, 64'h3333);
        idle(3);

        // randomized traffic on both instances
        for (int c = 0; c < 800; c++) begin
            for (int d = 0; d < 2; d++) begin
                iv[d]    = 1'($urandom_range(0, 1));
                isel[d]  = 3'($urandom_range(0, 7));
                idata[d] = {$urandom, $urandom};
                ordy[d]  = 8'($urandom | $urandom);
            end
            idle(1);
        end
        iv   = '0;
        ordy = {8'hFF, 8'hFF};
        idle(5);

        // reset while holding two beats
        ordy[0] = 8'h00;
        send(0, 3'd4, 64'h4444_4444);
        send(0, 3'd1, 64'h1010_1010);
        idle(2);
        reset = 1'b1;
        idle(2);
        reset   = 1'b0;
        ordy[0] = 8'hFF;
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
